// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, widths and the LFSR step function for the lfsr_seq block.
//   LFSR_W           - LFSR state/tap width
//   CNT_W            - step-count width
//   lfsr_seq_state_t - sequencer FSM states
//   lfsr_step()      - one Fibonacci-style shift with programmable feedback taps
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } lfsr_seq_state_t;

    // Shift left; the new LSB is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] state,
                                                    input logic [LFSR_W-1:0] taps);
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_seq_if.sv
// lfsr_seq_if: command stream, abort, output beat stream and status for lfsr_seq.
//   cmd_valid/cmd_ready          - command handshake (taps, seed, count)
//   abort                        - cancel the running command
//   out_valid/out_ready          - beat handshake (out_data, out_last)
//   busy, done, period_hit       - status
// master: host/consumer side.  slave: the sequencer.
interface lfsr_seq_if
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W,
    parameter int unsigned CNT_W = lfsr_pkg::CNT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_taps;
    logic [WIDTH-1:0] cmd_seed;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             period_hit;

    modport master (
        output cmd_valid, cmd_taps, cmd_seed, cmd_count, abort, out_ready,
        input  cmd_ready, out_valid, out_data, out_last, busy, done, period_hit
    );

    modport slave (
        input  cmd_valid, cmd_taps, cmd_seed, cmd_count, abort, out_ready,
        output cmd_ready, out_valid, out_data, out_last, busy, done, period_hit
    );

endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: tap register and LFSR state register, driven by the lfsr_seq FSM.
//   clock, reset - clock and asynchronous active-high reset
//   tap_we       - write tap_wdata into the tap register
//   load         - state <= step(load_seed) using the taps being written this cycle
//   advance      - state <= step(state) using the stored taps
//   taps, state  - current register contents
// WIDTH must equal lfsr_pkg::LFSR_W since the step function is fixed-width.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tap_we,
    input  logic [WIDTH-1:0] tap_wdata,
    input  logic             load,
    input  logic [WIDTH-1:0] load_seed,
    input  logic             advance,
    output logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] taps_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] load_taps;

    // A load in the same cycle as a tap write must already see the new taps.
    assign load_taps = tap_we ? tap_wdata : taps_q;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = lfsr_step(load_seed, load_taps);
        end else if (advance) begin
            state_d = lfsr_step(state_q, taps_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taps_q  <= '0;
            state_q <= '0;
        end else begin
            if (tap_we) begin
                taps_q <= tap_wdata;
            end
            state_q <= state_d;
        end
    end

    assign taps  = taps_q;
    assign state = state_q;

endmodule

// File: rtl/lfsr_seq.sv
// lfsr_seq: command-driven sequencer for the programmable-tap LFSR.
//   clock, reset - clock and asynchronous active-high reset
//   bus (slave)  - command in {taps, seed, count}, abort, beat stream out
//                  (out_data/out_last), status busy/done/period_hit
// Accepts a command in IDLE, writes the taps and first state in LOAD, then
// emits `count` beats in RUN, one per handshake.
module lfsr_seq
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W,
    parameter int unsigned CNT_W = lfsr_pkg::CNT_W
) (
    input logic        clock,
    input logic        reset,
    lfsr_seq_if.slave  bus
);

    lfsr_seq_state_t state_q;
    lfsr_seq_state_t state_d;

    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] idx_q;
    logic             done_q;
    logic             period_hit_q;

    logic             accept;
    logic             handshake;
    logic             last_beat;
    logic             tap_we;
    logic             load;
    logic             advance;
    logic [WIDTH-1:0] lfsr_taps;
    logic [WIDTH-1:0] lfsr_state;

    assign accept    = (state_q == IDLE) && bus.cmd_valid;
    assign handshake = (state_q == RUN) && bus.out_ready;
    assign last_beat = (idx_q == count_q);

    lfsr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .tap_we    (tap_we),
        .tap_wdata (bus.cmd_taps),
        .load      (load),
        .load_seed (seed_q),
        .advance   (advance),
        .taps      (lfsr_taps),
        .state     (lfsr_state)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.abort || (count_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort || (handshake && last_beat)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == RUN);
        bus.out_data  = (state_q == RUN) ? lfsr_state : '0;
        bus.out_last  = (state_q == RUN) && last_beat;
        tap_we        = (state_q == LOAD);
        load          = (state_q == LOAD);
        // Past the final beat the LFSR is left holding the last emitted value.
        advance       = handshake && !last_beat;
    end

    // Command fields, beat index and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seed_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            done_q       <= 1'b0;
            period_hit_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                seed_q       <= bus.cmd_seed;
                count_q      <= bus.cmd_count;
                period_hit_q <= 1'b0;
            end
            if (state_q == LOAD) begin
                idx_q <= CNT_W'(1);
                if ((count_q == '0) && !bus.abort) begin
                    done_q <= 1'b1;
                end
            end
            if (handshake) begin
                // The beat is delivered even if abort arrives with it.
                if (lfsr_state == seed_q) begin
                    period_hit_q <= 1'b1;
                end
                if (last_beat) begin
                    if (!bus.abort) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.done       = done_q;
    assign bus.period_hit = period_hit_q;

endmodule

// File: tb/tb_lfsr_seq.sv
// tb_lfsr_seq: directed and randomized checks of lfsr_seq against a beat-list model.
module tb_lfsr_seq;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    lfsr_seq_if #(.WIDTH(8), .CNT_W(16)) bus ();

    lfsr_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift left, feed back the parity of the tapped bits.
    function automatic logic [7:0] model_step(input logic [7:0] s, input logic [7:0] t);
        int v;
        v = (int'(s) * 2) + ($countones(s & t) % 2);
        return v[7:0];
    endfunction

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    // abort_at: beat number during which abort is raised (0 = never), with ready = abort_rdy.
    task automatic run_cmd(input logic [7:0] taps, input logic [7:0] seed, input int cnt,
                           input int mode, input int abort_at, input bit abort_rdy);
        logic [7:0] exp_q[$];
        logic [7:0] s;
        bit         ph;
        bit         fin;
        bit         rdy;
        int         k;
        int         pat;
        s = seed;
        exp_q = {};
        exp_q.push_back(8'h00);
        for (int i = 1; i <= cnt; i++) begin
            s = model_step(s, taps);
            exp_q.push_back(s);
        end
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_taps  = taps;
        bus.cmd_seed  = seed;
        bus.cmd_count = cnt[15:0];
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        chk("load_busy", 32'(bus.busy), 32'd1);
        chk("load_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("load_out_valid", 32'(bus.out_valid), 32'd0);
        chk("load_period_hit", 32'(bus.period_hit), 32'd0);
        @(negedge clock);
        if (cnt == 0) begin
            chk("cnt0_done", 32'(bus.done), 32'd1);
            chk("cnt0_out_valid", 32'(bus.out_valid), 32'd0);
            chk("cnt0_taps", 32'(dut.u_core.taps_q), 32'(taps));
            @(negedge clock);
            chk("cnt0_done_drop", 32'(bus.done), 32'd0);
            return;
        end
        k = 1;
        ph = 1'b0;
        fin = 1'b0;
        pat = 0;
        for (int budget = 0; budget < 4 * cnt + 8 && !fin; budget++) begin
            chk("beat_valid", 32'(bus.out_valid), 32'd1);
            chk("beat_data", 32'(bus.out_data), 32'(exp_q[k]));
            chk("beat_last", 32'(bus.out_last), 32'(k == cnt));
            chk("beat_period_hit", 32'(bus.period_hit), 32'(ph));
            chk("beat_done", 32'(bus.done), 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pat % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pat++;
            if (k == abort_at) rdy = abort_rdy;
            bus.out_ready = rdy;
            bus.abort     = (k == abort_at);
            @(negedge clock);
            bus.out_ready = 1'b0;
            bus.abort     = 1'b0;
            if (rdy && exp_q[k] == seed) ph = 1'b1;
            if ((rdy && k == cnt) || k == abort_at) begin
                fin = 1'b1;
                chk("end_out_valid", 32'(bus.out_valid), 32'd0);
                chk("end_done", 32'(bus.done), 32'(rdy && k == cnt && k != abort_at));
                chk("end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                chk("end_busy", 32'(bus.busy), 32'd0);
                chk("end_period_hit", 32'(bus.period_hit), 32'(ph));
            end else if (rdy) begin
                k++;
            end
        end
        chk("run_finished", 32'(fin), 32'd1);
        @(negedge clock);
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_period_hit"}, 32'(bus.period_hit), 32'd0);
        chk({tag, "_taps"}, 32'(dut.u_core.taps_q), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_taps  = '0;
        bus.cmd_seed  = '0;
        bus.cmd_count = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases
        run_cmd(8'hB8, 8'h01, 5, 0, 0, 1'b0);
        run_cmd(8'h80, 8'h01, 10, 0, 0, 1'b0);
        run_cmd(8'hB8, 8'h01, 5, 1, 0, 1'b0);
        run_cmd(8'h5A, 8'h33, 0, 0, 0, 1'b0);
        run_cmd(8'hB8, 8'h01, 5, 0, 3, 1'b0);
        run_cmd(8'h80, 8'h40, 4, 0, 0, 1'b0);
        run_cmd(8'hB8, 8'h01, 4, 0, 4, 1'b1);
        run_cmd(8'hE1, 8'h00, 4, 0, 0, 1'b0);

        // Reset asserted mid-run
        bus.cmd_valid = 1'b1;
        bus.cmd_taps  = 8'hB8;
        bus.cmd_seed  = 8'h01;
        bus.cmd_count = 16'd5;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("midrun");
        bus.out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("post_reset_done", 32'(bus.done), 32'd0);
        run_cmd(8'hB8, 8'h01, 5, 0, 0, 1'b0);

        // Randomized commands
        for (int n = 0; n < 6; n++) begin
            run_cmd(8'($urandom), 8'($urandom), int'($urandom_range(0, 14)), 2,
                    (n == 3) ? 2 : 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
